// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU op codes, funct values,
// internal ALU control codes and the multiplier FSM states.
package ex_pkg;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [5:0] FunctAdd  = 6'h20;
  localparam logic [5:0] FunctSub  = 6'h22;
  localparam logic [5:0] FunctAnd  = 6'h24;
  localparam logic [5:0] FunctOr   = 6'h25;
  localparam logic [5:0] FunctSlt  = 6'h2A;
  localparam logic [5:0] FunctMult = 6'h18;

  localparam logic [3:0] AluCtlAdd = 4'b0010;
  localparam logic [3:0] AluCtlSub = 4'b0110;
  localparam logic [3:0] AluCtlAnd = 4'b0000;
  localparam logic [3:0] AluCtlOr  = 4'b0001;
  localparam logic [3:0] AluCtlSlt = 4'b0111;
  localparam logic [3:0] AluCtlMul = 4'b1000;
  localparam logic [3:0] AluCtlInv = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StWait = 2'b10
  } ex_state_e;

endpackage

// File: rtl/ex_stage_alu_control.sv
// Maps (alu_op, funct) to the internal 4-bit ALU control code.
module alu_control
  import ex_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctl
);

  always_comb begin
    o_alu_ctl = AluCtlAdd;
    case (i_alu_op)
      AluOpAdd: o_alu_ctl = AluCtlAdd;
      AluOpSub: o_alu_ctl = AluCtlSub;
      AluOpFunct: begin
        case (i_funct)
          FunctAdd:  o_alu_ctl = AluCtlAdd;
          FunctSub:  o_alu_ctl = AluCtlSub;
          FunctAnd:  o_alu_ctl = AluCtlAnd;
          FunctOr:   o_alu_ctl = AluCtlOr;
          FunctSlt:  o_alu_ctl = AluCtlSlt;
          FunctMult: o_alu_ctl = AluCtlMul;
          default:   o_alu_ctl = AluCtlInv;
        endcase
      end
      default: o_alu_ctl = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target, destination select, iterative multiplier
// and the EX/MEM pipeline register with valid, stall and flush.
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        ready_out,
  input  logic        stall_in,
  input  logic        flush,
  input  logic [1:0]  wb_ctl,
  input  logic [2:0]  m_ctl,
  input  logic        reg_dest,
  input  logic        alu_src,
  input  logic [1:0]  alu_op,
  input  logic [31:0] npc,
  input  logic [31:0] r_data_1,
  input  logic [31:0] r_data_2,
  input  logic [31:0] sign_ext,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  output logic        out_valid,
  output logic [1:0]  wb_ctl_out,
  output logic [2:0]  m_ctl_out,
  output logic [31:0] branch_target,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] r_data_2_out,
  output logic [4:0]  write_reg
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES);
  localparam logic [CntW-1:0] LastIter = CntW'(MUL_CYCLES - 1);

  logic [31:0] w_op_b, w_alu_result, w_bt, w_mul_next;
  logic [3:0]  w_alu_ctl;
  logic [4:0]  w_wr;

  ex_state_e       r_state;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_acc, r_mcand, r_mplier;
  logic [1:0]      r_mul_wb;
  logic [2:0]      r_mul_m;
  logic [4:0]      r_mul_wr;
  logic [31:0]     r_mul_r2, r_mul_bt;

  alu_control u_alu_control (
    .i_alu_op  (alu_op),
    .i_funct   (sign_ext[5:0]),
    .o_alu_ctl (w_alu_ctl)
  );

  assign w_op_b     = alu_src ? sign_ext : r_data_2;
  assign w_bt       = npc + {sign_ext[29:0], 2'b00};
  assign w_wr       = reg_dest ? instr_1511 : instr_2016;
  assign ready_out  = (r_state == StIdle) && !stall_in && !flush;
  // One shift-add step; on the last iteration this is the final product.
  assign w_mul_next = r_mplier[0] ? r_acc + r_mcand : r_acc;

  always_comb begin
    w_alu_result = '0;
    case (w_alu_ctl)
      AluCtlAdd: w_alu_result = r_data_1 + w_op_b;
      AluCtlSub: w_alu_result = r_data_1 - w_op_b;
      AluCtlAnd: w_alu_result = r_data_1 & w_op_b;
      AluCtlOr:  w_alu_result = r_data_1 | w_op_b;
      AluCtlSlt: w_alu_result = {31'b0, $signed(r_data_1) < $signed(w_op_b)};
      default:   w_alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_mul_wb      <= '0;
      r_mul_m       <= '0;
      r_mul_wr      <= '0;
      r_mul_r2      <= '0;
      r_mul_bt      <= '0;
      out_valid     <= 1'b0;
      wb_ctl_out    <= '0;
      m_ctl_out     <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      alu_result    <= '0;
      r_data_2_out  <= '0;
      write_reg     <= '0;
    end else if (flush) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      out_valid  <= 1'b0;
      wb_ctl_out <= '0;
      m_ctl_out  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!stall_in) begin
            if (in_valid && (w_alu_ctl == AluCtlMul)) begin
              r_state    <= StMul;
              r_cnt      <= '0;
              r_acc      <= '0;
              r_mcand    <= r_data_1;
              r_mplier   <= w_op_b;
              r_mul_wb   <= wb_ctl;
              r_mul_m    <= m_ctl;
              r_mul_wr   <= w_wr;
              r_mul_r2   <= r_data_2;
              r_mul_bt   <= w_bt;
              out_valid  <= 1'b0;
              wb_ctl_out <= '0;
              m_ctl_out  <= '0;
            end else if (in_valid) begin
              out_valid     <= 1'b1;
              wb_ctl_out    <= wb_ctl;
              m_ctl_out     <= m_ctl;
              branch_target <= w_bt;
              zero          <= (w_alu_result == '0);
              alu_result    <= w_alu_result;
              r_data_2_out  <= r_data_2;
              write_reg     <= w_wr;
            end else begin
              out_valid  <= 1'b0;
              wb_ctl_out <= '0;
              m_ctl_out  <= '0;
            end
          end
        end
        StMul: begin
          r_acc    <= w_mul_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == LastIter) begin
            r_cnt <= '0;
            if (!stall_in) begin
              r_state       <= StIdle;
              out_valid     <= 1'b1;
              wb_ctl_out    <= r_mul_wb;
              m_ctl_out     <= r_mul_m;
              branch_target <= r_mul_bt;
              zero          <= (w_mul_next == '0);
              alu_result    <= w_mul_next;
              r_data_2_out  <= r_mul_r2;
              write_reg     <= r_mul_wr;
            end else begin
              r_state <= StWait;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (!stall_in) begin
              out_valid  <= 1'b0;
              wb_ctl_out <= '0;
              m_ctl_out  <= '0;
            end
          end
        end
        StWait: begin
          if (!stall_in) begin
            r_state       <= StIdle;
            out_valid     <= 1'b1;
            wb_ctl_out    <= r_mul_wb;
            m_ctl_out     <= r_mul_m;
            branch_target <= r_mul_bt;
            zero          <= (r_acc == '0);
            alu_result    <= r_acc;
            r_data_2_out  <= r_mul_r2;
            write_reg     <= r_mul_wr;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops plus
// hand-written multiplier, stall, flush and reset sequences.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, ready_out, stall_in, flush;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        reg_dest, alu_src;
  logic [1:0]  alu_op;
  logic [31:0] npc, r_data_1, r_data_2, sign_ext;
  logic [4:0]  instr_2016, instr_1511;
  logic        out_valid;
  logic [1:0]  wb_ctl_out;
  logic [2:0]  m_ctl_out;
  logic [31:0] branch_target;
  logic        zero;
  logic [31:0] alu_result, r_data_2_out;
  logic [4:0]  write_reg;

  int n_cmp = 0;
  int n_bad = 0;

  ex_stage #(.MUL_CYCLES(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .ready_out     (ready_out),
    .stall_in      (stall_in),
    .flush         (flush),
    .wb_ctl        (wb_ctl),
    .m_ctl         (m_ctl),
    .reg_dest      (reg_dest),
    .alu_src       (alu_src),
    .alu_op        (alu_op),
    .npc           (npc),
    .r_data_1      (r_data_1),
    .r_data_2      (r_data_2),
    .sign_ext      (sign_ext),
    .instr_2016    (instr_2016),
    .instr_1511    (instr_1511),
    .out_valid     (out_valid),
    .wb_ctl_out    (wb_ctl_out),
    .m_ctl_out     (m_ctl_out),
    .branch_target (branch_target),
    .zero          (zero),
    .alu_result    (alu_result),
    .r_data_2_out  (r_data_2_out),
    .write_reg     (write_reg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        src;
    logic        rdst;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] se;
    logic [31:0] npc;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] res;
    logic        z;
    logic [31:0] bt;
    logic [4:0]  wr;
  } vec_t;

  vec_t tbl [10];
  vec_t mv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    alu_op     = v.op;
    alu_src    = v.src;
    reg_dest   = v.rdst;
    r_data_1   = v.r1;
    r_data_2   = v.r2;
    sign_ext   = v.se;
    npc        = v.npc;
    instr_2016 = v.rt;
    instr_1511 = v.rd;
    wb_ctl     = v.wb;
    m_ctl      = v.m;
  endtask

  task automatic chk_vec(input string name, input vec_t v);
    chk({name, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, ".res"}, alu_result, v.res);
    chk({name, ".zero"}, {31'b0, zero}, {31'b0, v.z});
    chk({name, ".bt"}, branch_target, v.bt);
    chk({name, ".wr"}, {27'b0, write_reg}, {27'b0, v.wr});
    chk({name, ".wb"}, {30'b0, wb_ctl_out}, {30'b0, v.wb});
    chk({name, ".m"}, {29'b0, m_ctl_out}, {29'b0, v.m});
    chk({name, ".r2"}, r_data_2_out, v.r2);
  endtask

  initial begin
    //          op     src   rdst  r1            r2            se            npc
    //          rt     rd     wb     m       res           z     bt            wr
    tbl[0] = '{2'b10, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h0000002A, 32'h00000040,
               5'd9,  5'd5,  2'd1, 3'd2, 32'h00000001, 1'b0, 32'h000000E8, 5'd5};
    tbl[1] = '{2'b01, 1'b0, 1'b0, 32'h00000007, 32'h00000007, 32'hFFFFFFFF, 32'h00000100,
               5'd3,  5'd6,  2'd2, 3'd1, 32'h00000000, 1'b1, 32'h000000FC, 5'd3};
    tbl[2] = '{2'b00, 1'b1, 1'b0, 32'h00000010, 32'h12345678, 32'hFFFFFFF0, 32'h00000200,
               5'd8,  5'd1,  2'd3, 3'd4, 32'h00000000, 1'b1, 32'h000001C0, 5'd8};
    tbl[3] = '{2'b10, 1'b0, 1'b1, 32'hF0F01234, 32'h0FF0FF00, 32'h00000024, 32'h00000000,
               5'd2,  5'd31, 2'd0, 3'd7, 32'h00F01200, 1'b0, 32'h00000090, 5'd31};
    tbl[4] = '{2'b10, 1'b0, 1'b0, 32'hA0000001, 32'h00000F00, 32'h00000025, 32'h00000004,
               5'd17, 5'd1,  2'd1, 3'd0, 32'hA0000F01, 1'b0, 32'h00000098, 5'd17};
    tbl[5] = '{2'b10, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'h00000020, 32'h00000000,
               5'd0,  5'd30, 2'd2, 3'd3, 32'h00000001, 1'b0, 32'h00000080, 5'd30};
    tbl[6] = '{2'b10, 1'b0, 1'b1, 32'h00000000, 32'h00000001, 32'h00000022, 32'h00001000,
               5'd0,  5'd29, 2'd3, 3'd6, 32'hFFFFFFFF, 1'b0, 32'h00001088, 5'd29};
    tbl[7] = '{2'b10, 1'b0, 1'b1, 32'h00000005, 32'hFFFFFFFE, 32'h0000002A, 32'h00000000,
               5'd0,  5'd28, 2'd1, 3'd5, 32'h00000000, 1'b1, 32'h000000A8, 5'd28};
    tbl[8] = '{2'b10, 1'b0, 1'b1, 32'h00000001, 32'h00000001, 32'h0000003F, 32'h00000000,
               5'd0,  5'd27, 2'd3, 3'd5, 32'h00000000, 1'b1, 32'h000000FC, 5'd27};
    tbl[9] = '{2'b11, 1'b0, 1'b0, 32'h00000003, 32'h00000004, 32'h00000022, 32'h00000000,
               5'd11, 5'd0,  2'd2, 3'd2, 32'h00000007, 1'b0, 32'h00000088, 5'd11};

    rst_n = 1'b0;
    in_valid = 1'b0;
    stall_in = 1'b0;
    flush = 1'b0;
    drive(tbl[0]);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.ready", {31'b0, ready_out}, 32'd1);
    chk("rst.res", alu_result, 32'd0);
    chk("rst.zero", {31'b0, zero}, 32'd0);
    chk("rst.bt", branch_target, 32'd0);
    chk("rst.ctl", {27'b0, wb_ctl_out, m_ctl_out}, 32'd0);
    chk("rst.r2", r_data_2_out, 32'd0);
    chk("rst.wr", {27'b0, write_reg}, 32'd0);

    // Back-to-back single-cycle operations.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i]);
      tick();
      chk_vec($sformatf("vec%0d", i), tbl[i]);
    end

    in_valid = 1'b0;
    tick();
    chk("bubble.valid", {31'b0, out_valid}, 32'd0);
    chk("bubble.ctl", {27'b0, wb_ctl_out, m_ctl_out}, 32'd0);

    // Stall holds EX/MEM and blocks acceptance.
    in_valid = 1'b1;
    stall_in = 1'b1;
    drive(tbl[0]);
    #1;
    chk("stall.ready", {31'b0, ready_out}, 32'd0);
    tick();
    chk("stall.valid", {31'b0, out_valid}, 32'd0);
    chk("stall.res", alu_result, tbl[9].res);
    stall_in = 1'b0;
    tick();
    chk_vec("after_stall", tbl[0]);

    // Flush squashes a valid output and the incoming instruction.
    flush = 1'b1;
    drive(tbl[3]);
    #1;
    chk("flush.ready", {31'b0, ready_out}, 32'd0);
    tick();
    chk("flush.valid", {31'b0, out_valid}, 32'd0);
    chk("flush.ctl", {27'b0, wb_ctl_out, m_ctl_out}, 32'd0);
    flush = 1'b0;

    // mult -1 * 3 with the next instruction waiting upstream.
    mv = '{2'b10, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000003, 32'h00000018, 32'h00000300,
           5'd0, 5'd12, 2'd2, 3'd1, 32'hFFFFFFFD, 1'b0, 32'h00000360, 5'd12};
    drive(mv);
    tick();
    drive(tbl[9]);
    chk("mul1.ready0", {31'b0, ready_out}, 32'd0);
    chk("mul1.valid0", {31'b0, out_valid}, 32'd0);
    for (int k = 1; k < 32; k++) begin
      tick();
      chk($sformatf("mul1.busy%0d", k), {31'b0, ready_out}, 32'd0);
      chk($sformatf("mul1.bubble%0d", k), {31'b0, out_valid}, 32'd0);
    end
    tick();
    chk_vec("mul1.done", mv);
    chk("mul1.ready", {31'b0, ready_out}, 32'd1);
    tick();
    chk_vec("mul1.next", tbl[9]);

    // mult finishing under stall: WAIT until stall drops.
    mv = '{2'b10, 1'b0, 1'b1, 32'h12345678, 32'h00000100, 32'h00000018, 32'h00000000,
           5'd0, 5'd13, 2'd1, 3'd4, 32'h34567800, 1'b0, 32'h00000060, 5'd13};
    drive(mv);
    tick();
    in_valid = 1'b0;
    repeat (29) tick();
    chk("mul2.pre_valid", {31'b0, out_valid}, 32'd0);
    stall_in = 1'b1;
    for (int k = 30; k <= 40; k++) begin
      tick();
      chk($sformatf("mul2.frz_valid%0d", k), {31'b0, out_valid}, 32'd0);
      chk($sformatf("mul2.frz_res%0d", k), alu_result, 32'h00000007);
    end
    stall_in = 1'b0;
    #1;
    chk("mul2.wait_ready", {31'b0, ready_out}, 32'd0);
    tick();
    chk_vec("mul2.done", mv);
    chk("mul2.ready", {31'b0, ready_out}, 32'd1);
    tick();
    chk("mul2.bubble", {31'b0, out_valid}, 32'd0);

    // Flush at edge 10 of a mult with a simultaneous instruction.
    mv = '{2'b10, 1'b0, 1'b1, 32'h00000005, 32'h00000006, 32'h00000018, 32'h00000000,
           5'd0, 5'd14, 2'd3, 3'd7, 32'h0000001E, 1'b0, 32'h00000060, 5'd14};
    in_valid = 1'b1;
    drive(mv);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    in_valid = 1'b1;
    drive(tbl[9]);
    tick();
    chk("mflush.valid", {31'b0, out_valid}, 32'd0);
    chk("mflush.ctl", {27'b0, wb_ctl_out, m_ctl_out}, 32'd0);
    flush = 1'b0;
    drive(tbl[3]);
    #1;
    chk("mflush.ready", {31'b0, ready_out}, 32'd1);
    tick();
    chk_vec("mflush.next", tbl[3]);
    in_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk($sformatf("mflush.gone%0d", k), {31'b0, out_valid}, 32'd0);
    end
    chk("mflush.res_held", alu_result, tbl[3].res);

    // Reset mid-mult loses the product.
    in_valid = 1'b1;
    drive(mv);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst.res", alu_result, 32'd0);
    chk("mrst.wr", {27'b0, write_reg}, 32'd0);
    chk("mrst.ready", {31'b0, ready_out}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 34; k++) begin
      tick();
      chk($sformatf("mrst.gone%0d", k), {31'b0, out_valid}, 32'd0);
    end
    in_valid = 1'b1;
    drive(tbl[9]);
    tick();
    chk_vec("mrst.next", tbl[9]);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage sitting directly downstream of the ID/EX pipeline register; consumes its control, operand, sign-extend and register-field outputs.
- Computes the ALU result, zero flag, branch target and destination register number.
- Contains the EX/MEM pipeline register with valid, stall and flush.
- Adds a 32-cycle iterative multiplier for R-type mult, which back-pressures the ID/EX side while running.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations. Fixed at 32 for 32-bit operands; any other value is unsupported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  ID/EX holds a real instruction
- ready_out  out  1  stage accepts an instruction this edge; ID/EX holds when low
- stall_in  in  1  MEM side cannot accept; EX/MEM register holds
- flush  in  1  synchronous squash of the stage and its output
- wb_ctl  in  2  WB control from ID/EX
- m_ctl  in  3  MEM control from ID/EX
- reg_dest  in  1  1 selects instr_1511 as destination, 0 selects instr_2016
- alu_src  in  1  1 selects sign_ext as ALU operand B, 0 selects r_data_2
- alu_op  in  2  00 add, 01 sub, 10 decode funct
- npc  in  32  PC+4
- r_data_1, r_data_2  in  32  register operands
- sign_ext  in  32  sign-extended immediate; funct = sign_ext[5:0]
- instr_2016, instr_1511  in  5  rt and rd fields
- out_valid  out  1  EX/MEM contents are a real instruction
- wb_ctl_out  out  2  registered WB control
- m_ctl_out  out  3  registered MEM control
- branch_target  out  32  npc + (sign_ext << 2)
- zero  out  1  alu_result == 0
- alu_result  out  32  ALU or multiplier result
- r_data_2_out  out  32  store data
- write_reg  out  5  destination register

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, FSM in IDLE, iteration counter 0, multiplier accumulator 0. ready_out follows its combinational equation.
- ready_out = (state==IDLE) && !stall_in && !flush.
- Accept condition: in_valid && ready_out at a rising edge.
- ALU control (funct when alu_op=10):
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed compare), 0x18 mult.
  - Any other funct: result 0, instruction still passes with its controls.
  - alu_op=11: treated as add.
- Operand B = alu_src ? sign_ext : r_data_2.
- Arithmetic wraps modulo 2^32; no overflow detection.
- Multiplier returns the low 32 bits of the product, identical for signed and unsigned operands.
- Non-mult instruction: accepted at edge E; EX/MEM loads result, controls and fields at E, out_valid=1. Latency 1.
- Mult FSM:
  - IDLE→MUL on accept; latches operands and EX/MEM-bound fields; counter=0.
  - MUL: one bit per edge. After the 32nd iteration (edge E+32):
    - if !stall_in: load EX/MEM with out_valid=1 and go to IDLE;
    - else go to WAIT.
  - WAIT: holds the product; loads EX/MEM and goes to IDLE at the first edge with stall_in low.
- Bubbles: in IDLE, when there is no accept, no stall and no flush, EX/MEM loads out_valid=0, wb_ctl_out=0, m_ctl_out=0. Data fields are don't-care but held.
- While in MUL or WAIT with stall_in low, EX/MEM also loads bubbles.
- stall_in high: EX/MEM holds all fields. The multiplier keeps iterating and enters WAIT if it finishes under stall.
- flush has the highest priority:
  - EX/MEM out_valid, wb_ctl_out and m_ctl_out clear at the edge.
  - FSM returns to IDLE and any in-flight mult is discarded.
  - A simultaneous in_valid is discarded.
- Reset mid-mult: returns to IDLE and the product is lost.

Decomposition:
- Package ex_pkg:
  - alu_op codes
  - funct constants (0x20, 0x22, 0x24, 0x25, 0x2A, 0x18)
  - 4-bit alu_ctl codes: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1000 mul, 1111 invalid
  - FSM state enum: IDLE, MUL, WAIT
- Sub-module alu_control: combinational map from (alu_op, funct) to alu_ctl.
- Datapath, multiplier and EX/MEM register stay in ex_stage.

Test Plan:
- Reset release, in_valid=0 for 3 cycles → all outputs 0, ready_out=1, out_valid=0.
- alu_op=10, funct=0x2A, r1=0xFFFFFFFF, r2=1, reg_dest=1, rd=5 → after 1 edge: alu_result=1, zero=0, write_reg=5, out_valid=1.
- alu_op=01, r1=r2=7, npc=0x100, sign_ext=0xFFFFFFFF → alu_result=0, zero=1, branch_target=0xFC.
- mult r1=0xFFFFFFFF (-1), r2=3 → ready_out=0 for 32 cycles, then alu_result=0xFFFFFFFD, out_valid=1 exactly 32 edges after accept; upstream instruction held and accepted next.
- mult with stall_in held from edge 30 to 40 → FSM in WAIT, outputs frozen; result appears at the first edge after stall_in falls.
- flush at edge 10 of a mult, with in_valid=1 → out_valid=0, wb_ctl_out=0, FSM back in IDLE, next add accepted on the following edge with correct result.
